// File: rtl/truth_table_scanner.sv
// Stimulus/capture harness for a 4-input combinational function: walks a,b,c,d
// through all 16 vectors, captures f into a truth table and checks it against EXPECTED.
module truth_table_scanner #(
    parameter int unsigned SETTLE   = 1,
    parameter logic [15:0] EXPECTED = 16'hFFAF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        f_i,
    output logic        a_o,
    output logic        b_o,
    output logic        c_o,
    output logic        d_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [4:0]  err_count_o,
    output logic [15:0] tt_out_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    state_e      state_q;
    logic [3:0]  vec_q;
    logic [7:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [4:0]  err_q;
    logic [15:0] tt_q;

    logic [15:0] diff_d;
    logic [4:0]  err_d;
    logic        pass_d;

    // Comparison of the captured table against the golden one, consumed in CHECK.
    always_comb begin
        diff_d = tt_q ^ EXPECTED;
        err_d  = popcount16(diff_d);
        pass_d = (diff_d == 16'h0000);
    end

    // Scan controller: vector walk, settle counting, capture and result latch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            vec_q   <= 4'd0;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 5'd0;
            tt_q    <= 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_SCAN;
                        vec_q   <= 4'd0;
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= 5'd0;
                        tt_q    <= 16'h0000;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q        <= 8'd0;
                        tt_q[vec_q]  <= f_i;
                        if (vec_q == 4'd15) begin
                            state_q <= ST_CHECK;
                        end else begin
                            vec_q <= vec_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_CHECK: begin
                    err_q   <= err_d;
                    pass_q  <= pass_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    vec_q   <= 4'd0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    vec_q   <= 4'd0;
                    cnt_q   <= 8'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a_o         = vec_q[3];
    assign b_o         = vec_q[2];
    assign c_o         = vec_q[1];
    assign d_o         = vec_q[0];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign tt_out_o    = tt_q;

endmodule
